// File: rtl/sysbus_arbiter_if.sv
// Requester-side and system-bus-side handshake bundle for sysbus_arbiter.
// Requester vectors are packed flat, requester 0 in the least-significant slice.
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic [2:0]                  m_reqcyc;
    logic [3*BUS_DATA_WIDTH-1:0] m_req;
    logic [3*BUS_TAG_WIDTH-1:0]  m_reqtag;
    logic [2:0]                  m_reqack;
    logic [2:0]                  m_respcyc;
    logic [BUS_DATA_WIDTH-1:0]   m_resp;
    logic [BUS_TAG_WIDTH-1:0]    m_resptag;
    logic [2:0]                  m_respack;
    logic                        bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0]   bus_req;
    logic [BUS_TAG_WIDTH-1:0]    bus_reqtag;
    logic                        bus_reqack;
    logic                        bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0]   bus_resp;
    logic [BUS_TAG_WIDTH-1:0]    bus_resptag;
    logic                        bus_respack;

    // The arbiter is the bus master.
    modport master (
        input  m_reqcyc, m_req, m_reqtag, m_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output m_reqack, m_respcyc, m_resp, m_resptag,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output m_reqcyc, m_req, m_reqtag, m_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  m_reqack, m_respcyc, m_resp, m_resptag,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Three-requester system bus arbiter: one whole transaction (address + BEATS data beats) at a time.
// Define SYSBUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input logic              clk,
    input logic              reset,
    sysbus_arbiter_if.master sb
);
    localparam int unsigned RW_BIT      = 12;
    localparam logic        SYSBUS_READ = 1'b1;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    state_t     state;
    logic [1:0] gnt;
    logic [3:0] cnt;
    logic [1:0] pick;

    logic [BUS_DATA_WIDTH-1:0] g_req;
    logic [BUS_TAG_WIDTH-1:0]  g_tag;
    logic                      g_reqcyc;
    logic                      g_respack;
    logic                      wbeat;
    logic                      rbeat;
    logic                      last_beat;

    assign g_req     = sb.m_req[gnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign g_tag     = sb.m_reqtag[gnt*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
    assign g_reqcyc  = sb.m_reqcyc[gnt];
    assign g_respack = sb.m_respack[gnt];
    assign wbeat     = g_reqcyc & sb.bus_reqack;
    assign rbeat     = sb.bus_respcyc & g_respack;
    assign last_beat = (cnt == 4'(BEATS - 1));

`ifdef SYSBUS_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] c0, c1, c2;

    // Search order starts just after the last granted requester.
    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        case (rr_ptr)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: ;
        endcase
        if (sb.m_reqcyc[c0])      pick = c0;
        else if (sb.m_reqcyc[c1]) pick = c1;
        else                      pick = c2;
    end
`else
    always_comb begin
        if (sb.m_reqcyc[0])      pick = 2'd0;
        else if (sb.m_reqcyc[1]) pick = 2'd1;
        else                     pick = 2'd2;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= 2'd0;
            cnt    <= 4'd0;
`ifdef SYSBUS_ARB_RR_EN
            rr_ptr <= 2'd2;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|sb.m_reqcyc) begin
                        gnt    <= pick;
                        cnt    <= 4'd0;
                        state  <= ADDR;
`ifdef SYSBUS_ARB_RR_EN
                        rr_ptr <= pick;
`endif
                    end
                end
                ADDR: begin
                    if (sb.bus_reqack) begin
                        state <= (g_tag[RW_BIT] == SYSBUS_READ) ? RDATA : WDATA;
                    end
                end
                WDATA, RDATA: begin
                    if ((state == WDATA) ? wbeat : rbeat) begin
                        if (cnt != 4'hF) cnt <= cnt + 4'd1;
                        if (last_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the granted requester ever sees handshakes; everything idles at zero.
    always_comb begin
        sb.bus_reqcyc  = 1'b0;
        sb.bus_req     = '0;
        sb.bus_reqtag  = '0;
        sb.bus_respack = 1'b0;
        sb.m_reqack    = 3'b000;
        sb.m_respcyc   = 3'b000;
        sb.m_resp      = '0;
        sb.m_resptag   = '0;
        unique case (state)
            IDLE: ;
            ADDR: begin
                sb.bus_reqcyc = 1'b1;
                sb.bus_req    = g_req;
                sb.bus_reqtag = g_tag;
                sb.m_reqack   = 3'(sb.bus_reqack) << gnt;
            end
            WDATA: begin
                sb.bus_reqcyc = g_reqcyc;
                sb.bus_req    = g_req;
                sb.bus_reqtag = g_tag;
                sb.m_reqack   = 3'(sb.bus_reqack) << gnt;
            end
            RDATA: begin
                sb.m_respcyc   = 3'(sb.bus_respcyc) << gnt;
                sb.m_resp      = sb.bus_resp;
                sb.m_resptag   = sb.bus_resptag;
                sb.bus_respack = g_respack;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: grant table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_sysbus_arbiter;
    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;
    localparam logic [TW-1:0] TAG_RD = 13'h1300;
    localparam logic [TW-1:0] TAG_WR = 13'h0300;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) sb ();

    sysbus_arbiter #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (BEATS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]    reqcyc;
        logic [2:0]    exp_ack;
        logic          exp_reqcyc;
        logic [DW-1:0] exp_addr;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic bit bitn(input logic [2:0] v, input int k);
        return v[k[1:0]];
    endfunction

    function automatic logic [DW-1:0] req_of(input int i);
        return sb.m_req[i*DW +: DW];
    endfunction

    function automatic logic [TW-1:0] tag_of(input int i);
        return sb.m_reqtag[i*TW +: TW];
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] v);
        sb.m_req[i*DW +: DW] = v;
    endtask

    task automatic set_tag(input int i, input logic [TW-1:0] v);
        sb.m_reqtag[i*TW +: TW] = v;
    endtask

    task automatic idle_inputs();
        sb.m_reqcyc    = 3'b000;
        sb.m_req       = '0;
        sb.m_reqtag    = '0;
        sb.m_respack   = 3'b000;
        sb.bus_reqack  = 1'b0;
        sb.bus_respcyc = 1'b0;
        sb.bus_resp    = '0;
        sb.bus_resptag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bus_reqcyc"}, 64'(sb.bus_reqcyc), 64'd0);
        chk({name, "_bus_req"}, sb.bus_req, 64'd0);
        chk({name, "_m_reqack"}, 64'(sb.m_reqack), 64'd0);
        chk({name, "_m_respcyc"}, 64'(sb.m_respcyc), 64'd0);
        chk({name, "_bus_respack"}, 64'(sb.bus_respack), 64'd0);
        chk({name, "_m_resp"}, sb.m_resp, 64'd0);
    endtask

    function automatic int onehot_idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    // Reference arbitration straight from the policy rule.
    function automatic int pick(input logic [2:0] r, input int last);
`ifdef SYSBUS_ARB_RR_EN
        for (int k = 1; k <= 3; k++) if (bitn(r, (last + k) % 3)) return (last + k) % 3;
`else
        for (int k = 0; k < 3; k++) if (bitn(r, k)) return k;
`endif
        return -1;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats_seen, pulses, n, prev, p;
        int order [4];
        int exp_order [4];
        int cur, last, left;
        bit addr_ph, rd;
        logic [TW-1:0] t;
        logic e_reqcyc, e_respack, e_req_care, e_tag_care, e_resp_care;
        logic [2:0] e_reqack, e_respcyc;
        logic [DW-1:0] e_req, e_resp;
        logic [TW-1:0] e_tag, e_resptag;

        reset = 1'b1;
        idle_inputs();
        settle();
        chk_all_zero("in_reset");
        do_reset();
        settle();
        chk_all_zero("after_reset");

        // ---- grant table: first grant after reset is lowest index in both policies
        tbl[0] = '{3'b000, 3'b000, 1'b0, 64'h0};
        tbl[1] = '{3'b001, 3'b001, 1'b1, 64'hA000};
        tbl[2] = '{3'b010, 3'b010, 1'b1, 64'hA001};
        tbl[3] = '{3'b011, 3'b001, 1'b1, 64'hA000};
        tbl[4] = '{3'b100, 3'b100, 1'b1, 64'hA002};
        tbl[5] = '{3'b101, 3'b001, 1'b1, 64'hA000};
        tbl[6] = '{3'b110, 3'b010, 1'b1, 64'hA001};
        tbl[7] = '{3'b111, 3'b001, 1'b1, 64'hA000};
        for (int k = 0; k < 8; k++) begin
            do_reset();
            for (int i = 0; i < 3; i++) begin
                set_req(i, 64'hA000 + 64'(i));
                set_tag(i, TAG_WR);
            end
            sb.m_reqcyc = tbl[k].reqcyc;
            settle();
            chk("tbl_idle_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
            step();
            sb.bus_reqack = 1'b1;
            settle();
            chk("tbl_reqcyc", 64'(sb.bus_reqcyc), 64'(tbl[k].exp_reqcyc));
            chk("tbl_ack", 64'(sb.m_reqack), 64'(tbl[k].exp_ack));
            chk("tbl_addr", sb.bus_req, tbl[k].exp_addr);
        end

        // ---- requester 2 read, address acked on third ADDR cycle, respack stall on beat 4
        do_reset();
        set_req(2, 64'h1000);
        set_tag(2, TAG_RD);
        sb.m_reqcyc = 3'b100;
        step();
        for (int c = 0; c < 3; c++) begin
            sb.bus_reqack = (c == 2);
            settle();
            chk("r2_addr_cyc", 64'(sb.bus_reqcyc), 64'd1);
            chk("r2_addr", sb.bus_req, 64'h1000);
            chk("r2_tag", 64'(sb.bus_reqtag), 64'(TAG_RD));
            chk("r2_addr_ack", 64'(sb.m_reqack), (c == 2) ? 64'd4 : 64'd0);
            step();
        end
        sb.bus_reqack = 1'b0;
        sb.m_reqcyc   = 3'b000;
        beats_seen    = 0;
        for (int c = 0; c < 9; c++) begin
            sb.bus_respcyc = 1'b1;
            sb.bus_resp    = 64'hD000 + 64'(beats_seen);
            sb.bus_resptag = TAG_RD;
            sb.m_respack   = (c == 3) ? 3'b011 : 3'b111;
            settle();
            chk("r2_respcyc", 64'(sb.m_respcyc), 64'd4);
            chk("r2_data", sb.m_resp, 64'hD000 + 64'(beats_seen));
            chk("r2_respack", 64'(sb.bus_respack), (c == 3) ? 64'd0 : 64'd1);
            if (sb.m_respcyc[2] && sb.m_respack[2]) beats_seen++;
            step();
        end
        chk("r2_beats", 64'(beats_seen), 64'd8);
        // Spurious response beat in IDLE must be dropped.
        settle();
        chk("idle_drop_respcyc", 64'(sb.m_respcyc), 64'd0);
        chk("idle_drop_respack", 64'(sb.bus_respack), 64'd0);
        sb.bus_respcyc = 1'b0;

        // ---- requester 1 write: one address beat + BEATS data beats
        do_reset();
        set_tag(1, TAG_WR);
        sb.m_reqcyc    = 3'b010;
        sb.bus_reqack  = 1'b1;
        sb.bus_respcyc = 1'b1;
        sb.m_respack   = 3'b111;
        step();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            sb.m_reqcyc = (c < 9) ? 3'b010 : 3'b000;
            set_req(1, (c == 0) ? 64'h4000 : 64'hBEEF0000 + 64'(c));
            settle();
            if (sb.m_reqack[1]) pulses++;
            if (c < 9) chk("w1_bus_req", sb.bus_req, (c == 0) ? 64'h4000 : 64'hBEEF0000 + 64'(c));
            chk("w1_no_resp", 64'(sb.m_respcyc), 64'd0);
            step();
        end
        chk("w1_ack_pulses", 64'(pulses), 64'd9);
        settle();
        chk("w1_idle_reqcyc", 64'(sb.bus_reqcyc), 64'd0);

        // ---- request arriving in the final read beat is granted two cycles later
        do_reset();
        set_tag(2, TAG_RD);
        set_tag(0, TAG_WR);
        set_req(0, 64'h2000);
        sb.m_reqcyc = 3'b100;
        step();
        sb.bus_reqack = 1'b1;
        step();
        sb.bus_reqack  = 1'b0;
        sb.m_reqcyc    = 3'b000;
        sb.bus_respcyc = 1'b1;
        sb.m_respack   = 3'b100;
        for (int b = 0; b < BEATS; b++) begin
            if (b == BEATS - 1) sb.m_reqcyc = 3'b001;
            settle();
            chk("r24_beat", 64'(sb.m_respcyc), 64'd4);
            step();
        end
        settle();
        chk("r24_gap_reqcyc", 64'(sb.bus_reqcyc), 64'd0);
        chk("r24_gap_respcyc", 64'(sb.m_respcyc), 64'd0);
        step();
        settle();
        chk("r24_grant_reqcyc", 64'(sb.bus_reqcyc), 64'd1);
        chk("r24_grant_addr", sb.bus_req, 64'h2000);

        // ---- reset in the middle of a read, at beat 3
        do_reset();
        set_tag(0, TAG_RD);
        sb.m_reqcyc = 3'b001;
        step();
        sb.bus_reqack = 1'b1;
        step();
        sb.bus_reqack  = 1'b0;
        sb.bus_respcyc = 1'b1;
        sb.bus_resp    = 64'h55;
        sb.m_respack   = 3'b001;
        for (int b = 0; b < 3; b++) step();
        reset = 1'b1;
        settle();
        chk_all_zero("rst_mid");
        step();
        settle();
        chk_all_zero("rst_next");
        reset          = 1'b0;
        sb.bus_respcyc = 1'b0;
        set_tag(0, TAG_WR);
        set_req(0, 64'h3000);
        sb.bus_reqack = 1'b1;
        settle();
        chk("rst_rel_idle", 64'(sb.bus_reqcyc), 64'd0);
        step();
        settle();
        chk("rst_regrant_cyc", 64'(sb.bus_reqcyc), 64'd1);
        chk("rst_regrant_addr", sb.bus_req, 64'h3000);
        chk("rst_regrant_ack", 64'(sb.m_reqack), 64'd1);

        // ---- all three requesting and holding: grant order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(i, 64'hA000 + 64'(i));
            set_tag(i, TAG_WR);
        end
        sb.m_reqcyc   = 3'b111;
        sb.bus_reqack = 1'b1;
        prev = 0;
        n    = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            settle();
            if (sb.bus_reqcyc && prev == 0) begin
                order[n] = onehot_idx(sb.m_reqack);
                n++;
            end
            prev = int'(sb.bus_reqcyc);
            step();
        end
`ifdef SYSBUS_ARB_RR_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        chk("order_count", 64'(n), 64'd4);
        for (int k = 0; k < n; k++) chk("grant_order", 64'(order[k]), 64'(exp_order[k]));

        // ---- randomized run against the transaction-level model
        do_reset();
        cur  = -1;
        last = 2;
        left = 0;
        addr_ph = 1'b0;
        rd      = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            reset          = ($urandom_range(0, 299) == 0);
            sb.m_reqcyc    = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            sb.m_req       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            sb.m_reqtag    = 39'({$urandom(), $urandom()});
            sb.m_respack   = 3'($urandom_range(0, 7));
            sb.bus_reqack  = ($urandom_range(0, 2) != 0);
            sb.bus_respcyc = 1'($urandom_range(0, 1));
            sb.bus_resp    = {$urandom(), $urandom()};
            sb.bus_resptag = 13'($urandom());
            settle();

            e_reqcyc = 1'b0; e_req = '0; e_tag = '0; e_reqack = 3'b000;
            e_respcyc = 3'b000; e_resp = '0; e_resptag = '0; e_respack = 1'b0;
            e_req_care = 1'b1; e_tag_care = 1'b1; e_resp_care = 1'b1;
            if (!reset && cur >= 0) begin
                if (addr_ph) begin
                    e_reqcyc    = 1'b1;
                    e_req       = req_of(cur);
                    e_tag       = tag_of(cur);
                    e_reqack    = 3'(sb.bus_reqack) << cur;
                    e_resp_care = 1'b0;
                end else if (!rd) begin
                    e_reqcyc    = bitn(sb.m_reqcyc, cur);
                    e_req       = req_of(cur);
                    e_reqack    = 3'(sb.bus_reqack) << cur;
                    e_tag_care  = 1'b0;
                    e_resp_care = 1'b0;
                end else begin
                    e_respcyc  = 3'(sb.bus_respcyc) << cur;
                    e_resp     = sb.bus_resp;
                    e_resptag  = sb.bus_resptag;
                    e_respack  = bitn(sb.m_respack, cur);
                    e_req_care = 1'b0;
                    e_tag_care = 1'b0;
                end
            end
            chk("rnd_bus_reqcyc", 64'(sb.bus_reqcyc), 64'(e_reqcyc));
            chk("rnd_m_reqack", 64'(sb.m_reqack), 64'(e_reqack));
            chk("rnd_m_respcyc", 64'(sb.m_respcyc), 64'(e_respcyc));
            chk("rnd_bus_respack", 64'(sb.bus_respack), 64'(e_respack));
            if (e_req_care) chk("rnd_bus_req", sb.bus_req, e_req);
            if (e_tag_care) chk("rnd_bus_reqtag", 64'(sb.bus_reqtag), 64'(e_tag));
            if (e_resp_care) begin
                chk("rnd_m_resp", sb.m_resp, e_resp);
                chk("rnd_m_resptag", 64'(sb.m_resptag), 64'(e_resptag));
            end

            if (reset) begin
                cur  = -1;
                last = 2;
            end else if (cur < 0) begin
                p = pick(sb.m_reqcyc, last);
                if (p >= 0) begin
                    cur     = p;
                    last    = p;
                    addr_ph = 1'b1;
                end
            end else if (addr_ph) begin
                if (sb.bus_reqack) begin
                    t       = tag_of(cur);
                    addr_ph = 1'b0;
                    rd      = t[12];
                    left    = BEATS;
                end
            end else if (!rd) begin
                if (bitn(sb.m_reqcyc, cur) && sb.bus_reqack) begin
                    left--;
                    if (left == 0) cur = -1;
                end
            end else begin
                if (sb.bus_respcyc && bitn(sb.m_respack, cur)) begin
                    left--;
                    if (left == 0) cur = -1;
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data/address width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, tag width; bit 12 = SYSBUS_READ/WRITE, bits 11:8 = target.
REQ-003 SHALL have parameter BEATS, default 8, data beats per transaction (64-byte line).
REQ-004 SHALL have ports, in order:
  clk  in  1  clock.
  reset  in  1  reset; one clock; reset is asynchronous and active-high.
  m_reqcyc  in  3  per-requester request valid; index 0 = page walker, 1 = data, 2 = ifetch.
  m_req  in  3*BUS_DATA_WIDTH  per-requester address, then write data.
  m_reqtag  in  3*BUS_TAG_WIDTH  per-requester tag.
  m_reqack  out  3  per-requester request-beat accepted.
  m_respcyc  out  3  per-requester response beat valid.
  m_resp  out  BUS_DATA_WIDTH  response data, shared by all requesters.
  m_resptag  out  BUS_TAG_WIDTH  response tag, shared.
  m_respack  in  3  per-requester response-beat acknowledge.
  bus_reqcyc  out  1  bus request valid.
  bus_req  out  BUS_DATA_WIDTH  bus address/write data.
  bus_reqtag  out  BUS_TAG_WIDTH  bus tag.
  bus_reqack  in  1  bus accepted request beat.
  bus_respcyc  in  1  bus response beat valid.
  bus_resp  in  BUS_DATA_WIDTH  bus response data.
  bus_resptag  in  BUS_TAG_WIDTH  bus response tag.
  bus_respack  out  1  response-beat acknowledge to bus.

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, WDATA, RDATA plus 2-bit registered grant index gnt and 4-bit beat counter cnt.
REQ-006 IDLE: if any m_reqcyc set, SHALL register gnt per arbitration policy, clear cnt, enter ADDR next cycle; otherwise stay IDLE.
REQ-007 ADDR: SHALL drive bus_reqcyc=1, bus_req=m_req[gnt], bus_reqtag=m_reqtag[gnt]; m_reqack[gnt]=bus_reqack; on bus_reqack go to RDATA if tag bit 12 is READ, else WDATA.
REQ-008 WDATA: SHALL drive bus_reqcyc=m_reqcyc[gnt], bus_req=m_req[gnt], m_reqack[gnt]=bus_reqack; each cycle with bus_reqcyc&bus_reqack increments cnt; on the BEATS-th accepted beat return to IDLE.
REQ-009 RDATA: SHALL forward m_respcyc[gnt]=bus_respcyc, m_resp=bus_resp, m_resptag=bus_resptag, bus_respack=m_respack[gnt] combinationally; each cycle with bus_respcyc&bus_respack increments cnt; on the BEATS-th acknowledged beat return to IDLE.
REQ-010 Non-granted requesters SHALL see m_reqack=0 and m_respcyc=0 in every state; bus_reqcyc=0 and bus_respack=0 in IDLE.
REQ-011 Grant latency SHALL be exactly one cycle from m_reqcyc sampled in IDLE to bus_reqcyc asserted.
REQ-012 A request arriving in the cycle of a transaction's final beat SHALL be granted in the following IDLE cycle, never overlapping the prior transaction.
REQ-013 gnt SHALL remain stable from IDLE exit until IDLE re-entry; requester deassertion mid-transaction SHALL NOT change gnt or state.
REQ-014 Response beats with bus_respcyc=1 in IDLE, ADDR or WDATA SHALL be dropped: bus_respack=0, no m_respcyc.
REQ-015 cnt SHALL not wrap; it is cleared on every IDLE exit.

Reset
REQ-016 Reset assertion SHALL immediately force state=IDLE, gnt=0, cnt=0, round-robin pointer=2, independent of clk.
REQ-017 During and after reset, all outputs SHALL be 0 until a grant occurs; a reset mid-transaction SHALL abandon it with no further acks.

Configuration
REQ-018 Macro SYSBUS_ARB_RR_EN SHALL select policy: defined = round-robin, search starting at (last gnt+1) mod 3; undefined = fixed priority, lowest index wins.
REQ-019 With SYSBUS_ARB_RR_EN undefined, the round-robin pointer SHALL not be synthesised.

Verification
REQ-020 Reset mid-RDATA at beat 3 -> next cycle all outputs 0, state IDLE; new request granted normally after release.
REQ-021 m_reqcyc=3'b111 simultaneously, fixed priority -> grant order 0,0,... while 0 holds; with SYSBUS_ARB_RR_EN and all held -> order 0,1,2,0.
REQ-022 Requester 2 read addr 0x1000, bus acks after 2 cycles, 8 beats with one-cycle respack stall on beat 4 -> 8 m_respcyc[2] beats, data intact, IDLE after beat 8.
REQ-023 Requester 1 write, tag bit12=WRITE -> 1 address + 8 data beats on bus_req, m_reqack[1] pulses 9 times, no response forwarded.
REQ-024 Requester 0 raises m_reqcyc in final beat cycle of requester 2's read -> bus_reqcyc for requester 0 asserted exactly 2 cycles later.
REQ-025 Spurious bus_respcyc in IDLE -> bus_respack=0, all m_respcyc=0.
